md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 The block SHALL provide parameter MULT_CYC, default 5, the number of busy cycles for mult/multu.
REQ-002 The block SHALL provide parameter DIV_CYC, default 10, the number of busy cycles for div/divu.
REQ-003 The block SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL provide port start, input, 1, E-stage MDU instruction valid this cycle.
REQ-006 The block SHALL provide port md_op, input, 3, operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved.
REQ-007 The block SHALL provide port src_a, input, 32, forwarded rs value.
REQ-008 The block SHALL provide port src_b, input, 32, forwarded rt value.
REQ-009 The block SHALL provide port md_use, input, 1, D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 The block SHALL provide port busy, output, 1, multi-cycle operation in progress.
REQ-011 The block SHALL provide port stall, output, 1, freeze PC/IF-ID and bubble ID-EX.
REQ-012 The block SHALL provide port hi, output, 32, architectural HI register.
REQ-013 The block SHALL provide port lo, output, 32, architectural LO register.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-015 In IDLE, start=1 with md_op 0-3 SHALL, at the next edge, latch the full 64-bit result into an internal pending register, load cnt with MULT_CYC (ops 0-1) or DIV_CYC (ops 2-3), and enter BUSY.
REQ-016 Results SHALL be computed as follows:
- mult: signed 64-bit product.
- multu: unsigned 64-bit product.
- pending HI = product[63:32], pending LO = product[31:0].
REQ-017 Results for div SHALL be: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-018 Results for divu SHALL be: LO = unsigned quotient, HI = unsigned remainder.
REQ-019 div with src_a=0x80000000, src_b=0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0.
REQ-020 div/divu with src_b=0 SHALL still occupy DIV_CYC busy cycles and SHALL leave hi/lo unchanged at completion.
REQ-021 In BUSY, cnt SHALL decrement by 1 each edge. On the edge where cnt==1, hi/lo SHALL load the pending value and the FSM SHALL return to IDLE.
REQ-022 For a start sampled at edge T, busy SHALL be 1 for exactly N cycles (edges T..T+N) and hi/lo SHALL show the new value from edge T+N, the same edge busy falls.
REQ-023 busy SHALL be 1 exactly when state==BUSY, driven from a register.
REQ-024 In IDLE, start=1 with md_op 4 SHALL write src_a into hi at the next edge; md_op 5 SHALL write src_a into lo. Neither SHALL enter BUSY.
REQ-025 start=1 in BUSY, or start with md_op 6-7, SHALL be ignored: no change to state, cnt, pending, hi or lo.
REQ-026 stall SHALL be combinational: md_use & (busy | (start & md_op<=3)).
REQ-027 A new start SHALL be accepted in the cycle immediately after busy falls (back-to-back issue).
REQ-028 hi and lo SHALL change only at the events named in REQ-021 and REQ-024.

Reset
REQ-029 reset=0 SHALL, immediately and regardless of clk, force:
- state=IDLE, cnt=0, busy=0;
- hi=0, lo=0, pending=0.
REQ-030 An operation in progress at reset SHALL be abandoned with no write to hi/lo. Normal operation SHALL resume on the first edge after reset returns to 1.
REQ-031 stall SHALL evaluate to 0 while reset is asserted unless md_use & start & md_op<=3.

Verification
REQ-032 The bench SHALL cover mult: src_a=0xFFFFFFFF, src_b=2 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-033 The bench SHALL cover multu: same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-034 The bench SHALL cover div: src_a=-7 (0xFFFFFFF9), src_b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> hi/lo unchanged after 10 cycles.
REQ-035 The bench SHALL cover md_use=1 with busy=1 -> stall=1 every busy cycle. A start issued while busy -> no effect. md_use=0 while busy -> stall=0.
REQ-036 The bench SHALL cover mthi src_a=0x12345678 -> hi=0x12345678 next edge, busy stays 0. mtlo on the cycle after a mult completes -> lo overwritten.
REQ-037 The bench SHALL cover reset=0 asserted mid-div (cnt=4) -> busy=0, hi=lo=0 immediately. No later writeback occurs.

Source files
------------

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: MDU issue/status bundle between the pipeline and the HI/LO unit
interface md_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, md_op, src_a, src_b, md_use, input busy, stall, hi, lo);
    modport slave  (input start, md_op, src_a, src_b, md_use, output busy, stall, hi, lo);
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle mult/div controller owning the architectural HI/LO registers
module md_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input logic       clk,
    input logic       reset,
    md_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [63:0] pend, pend_nx, res;
    logic        pend_ok, pend_ok_nx;
    logic [31:0] hi_q, lo_q, hi_nx, lo_nx;
    logic [63:0] prod_s, prod_u;
    logic [31:0] ua, ub, ubd, uq, ur, q, r, sq, sr;
    logic        go;
    assign prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a}) * $signed({{32{bus.src_b[31]}}, bus.src_b});
    assign prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};
    // Signed divide via magnitudes; 0x80000000/-1 wraps naturally to 0x80000000 rem 0
    assign ua  = bus.src_a[31] ? -bus.src_a : bus.src_a;
    assign ub  = bus.src_b[31] ? -bus.src_b : bus.src_b;
    assign ubd = (ub == 32'd0) ? 32'd1 : ub;
    assign uq  = ua / ubd;
    assign ur  = ua % ubd;
    assign sq  = (bus.src_a[31] ^ bus.src_b[31]) ? -uq : uq;
    assign sr  = bus.src_a[31] ? -ur : ur;
    assign q   = bus.src_a / ((bus.src_b == 32'd0) ? 32'd1 : bus.src_b);
    assign r   = bus.src_a % ((bus.src_b == 32'd0) ? 32'd1 : bus.src_b);
    assign res = (bus.md_op[1:0] == 2'd0) ? prod_s :
                 (bus.md_op[1:0] == 2'd1) ? prod_u :
                 (bus.md_op[1:0] == 2'd2) ? {sr, sq} : {r, q};
    assign go  = (state == IDLE) && bus.start && (bus.md_op <= 3'd3);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend    <= 64'd0;
            pend_ok <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pend    <= pend_nx;
            pend_ok <= pend_ok_nx;
            hi_q    <= hi_nx;
            lo_q    <= lo_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pend_nx    = pend;
        pend_ok_nx = pend_ok;
        hi_nx      = hi_q;
        lo_nx      = lo_q;
        if (state == IDLE) begin
            if (go) begin
                state_nx   = BUSY;
                cnt_nx     = bus.md_op[1] ? 4'(DIV_CYC) : 4'(MULT_CYC);
                pend_nx    = res;
                pend_ok_nx = !(bus.md_op[1] && bus.src_b == 32'd0);
            end else if (bus.start && bus.md_op == 3'd4) begin
                hi_nx = bus.src_a;
            end else if (bus.start && bus.md_op == 3'd5) begin
                lo_nx = bus.src_a;
            end
        end else begin
            cnt_nx = cnt - 4'd1;
            if (cnt == 4'd1) begin
                state_nx = IDLE;
                if (pend_ok) {hi_nx, lo_nx} = pend;
            end
        end
    end
    assign bus.busy  = (state == BUSY);
    assign bus.stall = bus.md_use & (bus.busy | (bus.start & (bus.md_op <= 3'd3)));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed checks of md_ctrl timing, arithmetic, stall and reset
module tb_md_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    md_ctrl_if bus ();
    md_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        step();
        bus.start = 1'b0;
    endtask
    task automatic busy_for(input int n, input string tag, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_stall"}, 32'(bus.stall), 32'(bus.md_use));
            check({tag, "_hi_hold"}, bus.hi, hold_hi);
            check({tag, "_lo_hold"}, bus.lo, hold_lo);
            step();
        end
        check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    endtask
    initial begin
        bus.start = 1'b0; bus.md_op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0; bus.md_use = 1'b0;
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_stall_idle", 32'(bus.stall), 32'd0);
        bus.md_use = 1'b1; bus.start = 1'b1; bus.md_op = 3'd2; #1;
        check("rst_stall_start", 32'(bus.stall), 32'd1);
        bus.md_op = 3'd4; #1;
        check("rst_stall_mthi", 32'(bus.stall), 32'd0);
        bus.start = 1'b0;
        @(negedge clk) reset = 1'b1;
        step();
        // mult: -1 * 2 = -2
        bus.md_use = 1'b1; bus.start = 1'b1; bus.md_op = 3'd0; bus.src_a = 32'hFFFF_FFFF; bus.src_b = 32'd2; #1;
        check("mult_issue_stall", 32'(bus.stall), 32'd1);
        issue(3'd0, 32'hFFFF_FFFF, 32'd2);
        busy_for(5, "mult", 32'd0, 32'd0);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFE);
        issue(3'd5, 32'hCAFE_BABE, 32'd0);
        check("mtlo_lo", bus.lo, 32'hCAFE_BABE);
        check("mtlo_hi", bus.hi, 32'hFFFF_FFFF);
        check("mtlo_busy", 32'(bus.busy), 32'd0);
        issue(3'd4, 32'h1234_5678, 32'd0);
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        issue(3'd6, 32'h5555_5555, 32'd3);
        check("rsvd_busy", 32'(bus.busy), 32'd0);
        check("rsvd_hi", bus.hi, 32'h1234_5678);
        check("rsvd_lo", bus.lo, 32'hCAFE_BABE);
        // multu with md_use low, plus ignored starts while busy
        bus.md_use = 1'b0;
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        check("multu_nostall", 32'(bus.stall), 32'd0);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        issue(3'd2, 32'd100, 32'd3);
        busy_for(3, "multu", 32'h1234_5678, 32'hCAFE_BABE);
        check("multu_hi", bus.hi, 32'h0000_0001);
        check("multu_lo", bus.lo, 32'hFFFF_FFFE);
        // back-to-back div in the cycle busy falls
        bus.md_use = 1'b1;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        busy_for(10, "div", 32'h0000_0001, 32'hFFFF_FFFE);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd0);
        busy_for(10, "divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("divu0_hi", bus.hi, 32'hFFFF_FFFF);
        check("divu0_lo", bus.lo, 32'hFFFF_FFFD);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        busy_for(10, "divov", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("divov_lo", bus.lo, 32'h8000_0000);
        check("divov_hi", bus.hi, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        busy_for(10, "divu", 32'd0, 32'h8000_0000);
        check("divu_lo", bus.lo, 32'd14);
        check("divu_hi", bus.hi, 32'd2);
        // reset with cnt=4 in a div
        issue(3'd2, 32'd1000, 32'd9);
        for (int i = 0; i < 6; i++) step();
        check("mid_busy", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        check("arst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("post_busy", 32'(bus.busy), 32'd0);
        check("post_hi", bus.hi, 32'd0);
        check("post_lo", bus.lo, 32'd0);
        issue(3'd0, 32'd3, 32'hFFFF_FFFB);
        busy_for(5, "resume", 32'd0, 32'd0);
        check("resume_hi", bus.hi, 32'hFFFF_FFFF);
        check("resume_lo", bus.lo, 32'hFFFF_FFF1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
